// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave bus-cycle controller: synchronises 68000 strobes, latches one target per cycle,
// and drives DTACK/OVR enables. Define Z2_TIMEOUT_EN to abort hung DATA phases with a BERR request.
module z2_cycle_ctrl #(
  parameter int          NUM_TGT        = 5,
  parameter int          SYNC_STAGES    = 2,
  parameter logic [7:0]  OVR_MASK       = 8'b0001_0110,
  parameter int          TIMEOUT_W      = 8,
  parameter int          TIMEOUT_CYCLES = 200
) (
  input  logic               MEMCLK,
  input  logic               RESET_n,
  input  logic               AS_n,
  input  logic               UDS_n,
  input  logic               LDS_n,
  input  logic               RW,
  input  logic               BERR_n,
  input  logic [NUM_TGT-1:0] tgt_sel,
  input  logic [NUM_TGT-1:0] tgt_ready,
  output logic [2:0]         z2_state,
  output logic [NUM_TGT-1:0] active_tgt,
  output logic               as_sync_n,
  output logic               uds_sync_n,
  output logic               lds_sync_n,
  output logic               rw_sync,
  output logic               cycle_start,
  output logic               cycle_end,
  output logic               dtack_oe,
  output logic               ovr_oe,
  output logic               berr_req
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_END   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [NUM_TGT-1:0] OVR_M = OVR_MASK[NUM_TGT-1:0];

  if (TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
  end

  state_t               state_q;
  logic [SYNC_STAGES:0]   as_sh_q;
  logic [SYNC_STAGES-1:0] uds_sh_q, lds_sh_q, rw_sh_q, berr_sh_q;
  logic [NUM_TGT-1:0]   active_q;
  logic                 dtack_q, start_q, end_q;
  logic                 as_start_n, berr_sync_n, strobe_low, ready_hit;

  function automatic logic [NUM_TGT-1:0] lowest_bit(input logic [NUM_TGT-1:0] v);
    lowest_bit = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_bit    = '0;
        lowest_bit[i] = 1'b1;
      end
    end
  endfunction

  // AS_n carries one extra stage so the cycle only opens once decode has settled.
  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_sh_q   <= '1;
      uds_sh_q  <= '1;
      lds_sh_q  <= '1;
      rw_sh_q   <= '1;
      berr_sh_q <= '1;
    end else begin
      as_sh_q[0]   <= AS_n;
      uds_sh_q[0]  <= UDS_n;
      lds_sh_q[0]  <= LDS_n;
      rw_sh_q[0]   <= RW;
      berr_sh_q[0] <= BERR_n;
      for (int i = 1; i <= SYNC_STAGES; i++) as_sh_q[i] <= as_sh_q[i-1];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        uds_sh_q[i]  <= uds_sh_q[i-1];
        lds_sh_q[i]  <= lds_sh_q[i-1];
        rw_sh_q[i]   <= rw_sh_q[i-1];
        berr_sh_q[i] <= berr_sh_q[i-1];
      end
    end
  end

  assign as_sync_n   = as_sh_q[SYNC_STAGES-1];
  assign as_start_n  = as_sh_q[SYNC_STAGES];
  assign uds_sync_n  = uds_sh_q[SYNC_STAGES-1];
  assign lds_sync_n  = lds_sh_q[SYNC_STAGES-1];
  assign rw_sync     = rw_sh_q[SYNC_STAGES-1];
  assign berr_sync_n = berr_sh_q[SYNC_STAGES-1];
  assign strobe_low  = !uds_sync_n || !lds_sync_n;
  assign ready_hit   = |(tgt_ready & active_q);

`ifdef Z2_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 berr_q;
`endif

  // Abort on AS release beats external BERR, which beats target ready.
  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      dtack_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
`ifdef Z2_TIMEOUT_EN
      cnt_q    <= '0;
      berr_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dtack_q <= 1'b0;
          if (!as_start_n && |tgt_sel) begin
            state_q  <= ST_START;
            active_q <= lowest_bit(tgt_sel);
            start_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (as_sync_n) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            end_q    <= 1'b1;
          end else if (!berr_sync_n) begin
            state_q <= ST_END;
          end else if (strobe_low) begin
            state_q <= ST_DATA;
`ifdef Z2_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_DATA: begin
          if (as_sync_n) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            end_q    <= 1'b1;
          end else if (!berr_sync_n) begin
            state_q <= ST_END;
          end else if (ready_hit) begin
            state_q <= ST_END;
            dtack_q <= 1'b1;
          end
`ifdef Z2_TIMEOUT_EN
          else begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (cnt_q == TO_LAST) begin
              state_q <= ST_ERR;
              berr_q  <= 1'b1;
            end
          end
`endif
        end
        ST_END: begin
          if (as_sync_n) begin
            state_q  <= ST_IDLE;
            dtack_q  <= 1'b0;
            active_q <= '0;
            end_q    <= 1'b1;
          end
        end
`ifdef Z2_TIMEOUT_EN
        ST_ERR: begin
          if (as_sync_n) begin
            state_q  <= ST_IDLE;
            berr_q   <= 1'b0;
            active_q <= '0;
            end_q    <= 1'b1;
          end
        end
`endif
        default: begin
          state_q  <= ST_IDLE;
          active_q <= '0;
          dtack_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef Z2_TIMEOUT_EN
  assign berr_req = berr_q;
`else
  assign berr_req = 1'b0;
`endif

  assign z2_state    = state_q;
  assign active_tgt  = active_q;
  assign cycle_start = start_q;
  assign cycle_end   = end_q;
  // Raw AS_n gating lets both enables drop the instant the master ends the cycle.
  assign dtack_oe    = dtack_q && !AS_n && |(active_q & OVR_M);
  assign ovr_oe      = |(tgt_sel & OVR_M) && !AS_n;

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// Directed bench for z2_cycle_ctrl: table-driven read cycles plus hand sequences for
// abort, BERR priority, asynchronous reset and (with Z2_TIMEOUT_EN) the timeout path.
module tb_z2_cycle_ctrl;

  localparam int NT = 5;

  logic          MEMCLK = 1'b0;
  logic          RESET_n = 1'b1;
  logic          AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1, BERR_n = 1'b1;
  logic [NT-1:0] tgt_sel = '0, tgt_ready = '0;
  logic [2:0]    z2_state;
  logic [NT-1:0] active_tgt;
  logic          as_sync_n, uds_sync_n, lds_sync_n, rw_sync;
  logic          cycle_start, cycle_end, dtack_oe, ovr_oe, berr_req;

  int n_checks = 0;
  int n_pass   = 0;

  z2_cycle_ctrl #(
    .NUM_TGT(NT), .SYNC_STAGES(2), .OVR_MASK(8'b0001_0110),
    .TIMEOUT_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .MEMCLK(MEMCLK), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
    .RW(RW), .BERR_n(BERR_n), .tgt_sel(tgt_sel), .tgt_ready(tgt_ready),
    .z2_state(z2_state), .active_tgt(active_tgt), .as_sync_n(as_sync_n),
    .uds_sync_n(uds_sync_n), .lds_sync_n(lds_sync_n), .rw_sync(rw_sync),
    .cycle_start(cycle_start), .cycle_end(cycle_end), .dtack_oe(dtack_oe),
    .ovr_oe(ovr_oe), .berr_req(berr_req)
  );

  // clock / reset
  always #5 MEMCLK = ~MEMCLK;

  typedef struct {
    logic          as_n, uds_n, rw;
    logic [NT-1:0] sel, ready;
    logic [2:0]    e_state;
    logic [NT-1:0] e_active;
    logic          e_dtack, e_ovr, e_start, e_end, e_as_sync, e_rw_sync;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge MEMCLK);
      #1;
    end
  endtask

  task automatic push(input logic as_n, input logic uds_n, input logic rw,
                      input logic [NT-1:0] sel, input logic [NT-1:0] ready,
                      input logic [2:0] st, input logic [NT-1:0] act, input logic dt,
                      input logic ov, input logic cs, input logic ce,
                      input logic asy, input logic rwy);
    vec_t v;
    v.as_n = as_n; v.uds_n = uds_n; v.rw = rw; v.sel = sel; v.ready = ready;
    v.e_state = st; v.e_active = act; v.e_dtack = dt; v.e_ovr = ov;
    v.e_start = cs; v.e_end = ce; v.e_as_sync = asy; v.e_rw_sync = rwy;
    vecs.push_back(v);
  endtask

  // One full read/write cycle: strobes low together, sel_late applied after START.
  task automatic add_cycle(input logic [NT-1:0] sel, input logic [NT-1:0] sel_late,
                           input logic [NT-1:0] ready, input logic rw,
                           input logic [NT-1:0] act, input logic dt, input logic ov,
                           input logic ov_late);
    logic rwy;
    rwy = rw;
    push(0, 0, rw, sel,      ready, 3'd0, '0,  0,  ov,      0, 0, 1, 1);
    push(0, 0, rw, sel,      ready, 3'd0, '0,  0,  ov,      0, 0, 0, rwy);
    push(0, 0, rw, sel,      ready, 3'd0, '0,  0,  ov,      0, 0, 0, rwy);
    push(0, 0, rw, sel,      ready, 3'd1, act, 0,  ov,      1, 0, 0, rwy);
    push(0, 0, rw, sel_late, ready, 3'd2, act, 0,  ov_late, 0, 0, 0, rwy);
    push(0, 0, rw, sel_late, ready, 3'd3, act, dt, ov_late, 0, 0, 0, rwy);
    push(0, 0, rw, sel_late, ready, 3'd3, act, dt, ov_late, 0, 0, 0, rwy);
    push(1, 1, 1,  '0,       '0,    3'd3, act, 0,  0,       0, 0, 0, rwy);
    push(1, 1, 1,  '0,       '0,    3'd3, act, 0,  0,       0, 0, 1, 1);
    push(1, 1, 1,  '0,       '0,    3'd0, '0,  0,  0,       0, 1, 1, 1);
    push(1, 1, 1,  '0,       '0,    3'd0, '0,  0,  0,       0, 0, 1, 1);
  endtask

  task automatic idle_inputs();
    AS_n = 1; UDS_n = 1; LDS_n = 1; RW = 1; BERR_n = 1; tgt_sel = '0; tgt_ready = '0;
  endtask

  initial begin
    // reset
    #1 RESET_n = 0;
    #2;
    chk("rst_state",  z2_state, 3'd0);
    chk("rst_active", active_tgt, '0);
    chk("rst_dtack",  dtack_oe, 0);
    chk("rst_berr",   berr_req, 0);
    chk("rst_pulses", {cycle_start, cycle_end}, 2'b00);
    chk("rst_sync",   {as_sync_n, uds_sync_n, lds_sync_n, rw_sync}, 4'b1111);
    tick(2);
    RESET_n = 1;
    tick(1);

    // table: target 2 read with late decode change, then targets 0+2 write (target 0 wins, mask 0)
    add_cycle(5'b00100, 5'b00110, 5'b00100, 1'b1, 5'b00100, 1'b1, 1'b1, 1'b1);
    add_cycle(5'b00101, 5'b00101, 5'b00101, 1'b0, 5'b00001, 1'b0, 1'b1, 1'b1);
    for (int r = 0; r < vecs.size(); r++) begin
      AS_n = vecs[r].as_n; UDS_n = vecs[r].uds_n; RW = vecs[r].rw;
      tgt_sel = vecs[r].sel; tgt_ready = vecs[r].ready;
      tick(1);
      chk($sformatf("row%0d_state", r),   z2_state,    vecs[r].e_state);
      chk($sformatf("row%0d_active", r),  active_tgt,  vecs[r].e_active);
      chk($sformatf("row%0d_dtack", r),   dtack_oe,    vecs[r].e_dtack);
      chk($sformatf("row%0d_ovr", r),     ovr_oe,      vecs[r].e_ovr);
      chk($sformatf("row%0d_start", r),   cycle_start, vecs[r].e_start);
      chk($sformatf("row%0d_end", r),     cycle_end,   vecs[r].e_end);
      chk($sformatf("row%0d_as_sync", r), as_sync_n,   vecs[r].e_as_sync);
      chk($sformatf("row%0d_rw_sync", r), rw_sync,     vecs[r].e_rw_sync);
      chk($sformatf("row%0d_berr", r),    berr_req,    1'b0);
    end

    // abort: AS released in DATA with no ready
    idle_inputs();
    AS_n = 0; UDS_n = 0; tgt_sel = 5'b00010;
    tick(5);
    chk("abort_in_data", z2_state, 3'd2);
    AS_n = 1; UDS_n = 1; tgt_sel = '0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk($sformatf("abort_wait%0d", i), z2_state, 3'd2);
      chk($sformatf("abort_dtack%0d", i), dtack_oe, 0);
    end
    tick(1);
    chk("abort_idle",   z2_state, 3'd0);
    chk("abort_end",    cycle_end, 1);
    chk("abort_active", active_tgt, '0);
    tick(1);
    chk("abort_end_pulse", cycle_end, 0);

    // BERR synced low in the same clock that tgt_ready is seen
    idle_inputs();
    AS_n = 0; UDS_n = 0; tgt_sel = 5'b00100;
    tick(5);
    chk("berr_in_data", z2_state, 3'd2);
    BERR_n = 0;
    tick(2);
    chk("berr_still_data", z2_state, 3'd2);
    tgt_ready = 5'b00100;
    tick(1);
    chk("berr_to_end", z2_state, 3'd3);
    chk("berr_dtack0", dtack_oe, 0);
    tick(1);
    chk("berr_dtack1", dtack_oe, 0);
    idle_inputs();
    tick(3);
    chk("berr_idle", z2_state, 3'd0);
    chk("berr_end",  cycle_end, 1);

    // asynchronous reset while holding DTACK in END
    idle_inputs();
    tick(2);
    AS_n = 0; UDS_n = 0; tgt_sel = 5'b00100; tgt_ready = 5'b00100;
    tick(6);
    chk("pre_reset_state", z2_state, 3'd3);
    chk("pre_reset_dtack", dtack_oe, 1);
    #3 RESET_n = 0;
    #1;
    chk("arst_state",  z2_state, 3'd0);
    chk("arst_dtack",  dtack_oe, 0);
    chk("arst_active", active_tgt, '0);
    idle_inputs();
    tick(2);
    RESET_n = 1;
    tick(2);

`ifdef Z2_TIMEOUT_EN
    // hung DATA phase: BERR request on the 16th DATA clock
    AS_n = 0; UDS_n = 0; tgt_sel = 5'b00100;
    tick(5);
    chk("to_in_data", z2_state, 3'd2);
    for (int i = 1; i < 16; i++) begin
      tick(1);
      chk($sformatf("to_wait%0d", i), berr_req, 0);
    end
    tick(1);
    chk("to_berr",  berr_req, 1);
    chk("to_state", z2_state, 3'd4);
    chk("to_dtack", dtack_oe, 0);
    idle_inputs();
    tick(3);
    chk("to_idle",    z2_state, 3'd0);
    chk("to_cleared", berr_req, 0);
    chk("to_end",     cycle_end, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/z2_cycle_ctrl.md
Name: z2_cycle_ctrl

Overview:
- Parametrised Zorro II slave bus-cycle controller for the CIDER CPLD. Generalises the fixed top-level Z2 state machine into an N-target arbiter.
- Synchronises the 68000 strobes into MEMCLK and latches one active target per cycle. Generates registered DTACK, combinational OVR enable and cycle-boundary strobes.
- Optionally aborts hung cycles with a bus-error request.
- Sits between the address decoders (autoconfig, SDRAM, IDE, control, flash) and the DTACK_n/OVR_n/BERR_n pad drivers.

Parameters:
- NUM_TGT, 5, number of target channels (1..8).
- SYNC_STAGES, 2, synchroniser depth for UDS_n/LDS_n/RW/BERR_n; AS_n start path uses SYNC_STAGES+1.
- OVR_MASK, 5'b10110, bit i=1: target i drives external DTACK/OVR (on-chip register targets leave it 0).
- TIMEOUT_W, 8, timeout counter width.
- TIMEOUT_CYCLES, 200, MEMCLK cycles in DATA before abort; must be < 2^TIMEOUT_W.

Ports:
- MEMCLK  in  1  system clock.
- RESET_n  in  1  asynchronous, active-low reset.
- AS_n  in  1  raw address strobe (async).
- UDS_n  in  1  raw upper data strobe (async).
- LDS_n  in  1  raw lower data strobe (async).
- RW  in  1  raw read/write (async).
- BERR_n  in  1  raw external bus error (async).
- tgt_sel  in  NUM_TGT  address-decode hit per target, combinational from ADDR.
- tgt_ready  in  NUM_TGT  per-target data-ready request, level.
- z2_state  out  3  current state encoding.
- active_tgt  out  NUM_TGT  one-hot latched target, 0 when idle.
- as_sync_n, uds_sync_n, lds_sync_n, rw_sync  out  1 each  synchronised strobes for targets.
- cycle_start  out  1  one-clock pulse on IDLE->START.
- cycle_end  out  1  one-clock pulse on END->IDLE or on abort to IDLE.
- dtack_oe  out  1  drive DTACK_n low.
- ovr_oe  out  1  drive OVR_1_n/OVR_2_n low.
- berr_req  out  1  drive BERR_n low (Z2_TIMEOUT_EN only, else 0).

Behaviour:
- Reset (async): state IDLE (3'd0), active_tgt=0, synchronisers all-ones (rw_sync=1), dtack=0, pulses=0, berr_req=0, counter=0.
- States: IDLE=0, START=1, DATA=2, END=3, ERR=4.
- IDLE: dtack=0. If AS_n stage SYNC_STAGES+1 is low and |tgt_sel, go START. Latch active_tgt = lowest-index set bit of tgt_sel; pulse cycle_start.
- START: go DATA when uds_sync_n==0 or lds_sync_n==0.
- DATA: when tgt_ready[active] is 1, set dtack=1 and go END. Latency from strobe-low sync to dtack is one clock; tgt_ready of non-active targets is ignored.
- END: wait for as_sync_n==1 (SYNC_STAGES path). Then dtack=0, active_tgt=0, go IDLE, pulse cycle_end.
- Abort: as_sync_n==1 while in START or DATA → IDLE with no dtack; cycle_end pulses.
- Synced BERR_n low in START/DATA → END with dtack held 0.
- Priority when several conditions hold in the same clock: AS abort > BERR > tgt_ready.
- dtack_oe = dtack & ~AS_n(raw) & OVR_MASK[active].
- ovr_oe = |(tgt_sel & OVR_MASK) & ~AS_n(raw), combinational so OVR asserts before the first MEMCLK edge.
- No re-arbitration mid-cycle: tgt_sel changes after START are ignored until IDLE.
- State encodings 5..7 are illegal and recover to IDLE on the next clock.

Optional Feature:
- Z2_TIMEOUT_EN defined:
  - Counter clears on entering DATA and increments each DATA clock.
  - At TIMEOUT_CYCLES → ERR with berr_req=1.
  - ERR holds until as_sync_n==1, then clears berr_req → IDLE with cycle_end.
  - Counter saturates and does not wrap.
- Z2_TIMEOUT_EN undefined:
  - No counter or ERR state; DATA waits indefinitely.
  - berr_req tied 0.

Test Plan:
- Read, target 2 (mask=1): AS low, UDS low, tgt_ready[2]=1 → cycle_start once; DATA→END; dtack_oe=1 until AS high; cycle_end once; state back to 0.
- tgt_sel=5'b00101 together: active_tgt=5'b00001 (target 0, mask=0) → ovr_oe=1 due to target 2 decode, but dtack_oe stays 0 throughout.
- AS high in DATA with tgt_ready=0 → IDLE within SYNC_STAGES+1 clocks; dtack never asserted; cycle_end pulses.
- Async reset while in END with dtack=1 → z2_state=0, dtack_oe=0, active_tgt=0 immediately, no clock required.
- Z2_TIMEOUT_EN, TIMEOUT_CYCLES=16, tgt_ready stuck 0 → berr_req=1 on the 16th DATA clock; cleared after AS high; no dtack.
- BERR_n low in DATA with tgt_ready=1 in the same clock → END, dtack_oe stays 0.
